tlc_phase_scheduler: RTL

//  Shares a single right-of-way ("green") among N_APPROACH intersection approaches.

---
 rtl/tlc_phase_scheduler_pkg.sv | 17 +
 rtl/tlc_phase_scheduler_if.sv | 39 +++
 rtl/tlc_phase_scheduler_rr_arbiter.sv | 28 ++
 rtl/tlc_phase_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tlc_phase_scheduler_pkg.sv
// Shared types for the traffic-light phase scheduler (package tlc_pkg).
// Lamp encodings match the lamp-driver wiring; phases are the controller FSM states.
package tlc_pkg;

  typedef enum logic [1:0] {
    LT_GREEN  = 2'b00,
    LT_YELLOW = 2'b01,
    LT_RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_ALL_RED
  } phase_t;

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Approach-side bundle of the phase scheduler: sensors in, lamps/grant out.
// TLC_PREEMPT_EN adds the emergency-vehicle preempt request signals.
interface tlc_phase_scheduler_if #(
  parameter int N_APPROACH = 4,
  parameter int IDX_W      = $clog2(N_APPROACH)
);

  logic [N_APPROACH-1:0]   req;
  logic [2*N_APPROACH-1:0] light;
  logic [N_APPROACH-1:0]   grant;
  logic [IDX_W-1:0]        cur_idx;
  logic                    phase_start;

`ifdef TLC_PREEMPT_EN
  logic                    preempt;
  logic [IDX_W-1:0]        preempt_idx;

  modport master (
    input  req, preempt, preempt_idx,
    output light, grant, cur_idx, phase_start
  );

  modport slave (
    output req, preempt, preempt_idx,
    input  light, grant, cur_idx, phase_start
  );
`else
  modport master (
    input  req,
    output light, grant, cur_idx, phase_start
  );

  modport slave (
    output req,
    input  light, grant, cur_idx, phase_start
  );
`endif

endinterface

// File: rtl/tlc_phase_scheduler_rr_arbiter.sv
// Combinational round-robin pick of the next approach to receive green.
// Searches cur_idx+1, cur_idx+2, ... (mod N_APPROACH); the current owner never wins.
module tlc_rr_arbiter #(
  parameter int N_APPROACH = 4,
  parameter int IDX_W      = $clog2(N_APPROACH)
) (
  input  logic [N_APPROACH-1:0] req,
  input  logic [IDX_W-1:0]      cur_idx,
  output logic [IDX_W-1:0]      winner,
  output logic                  valid
);

  // Walk from farthest to nearest so the nearest requester overwrites earlier hits.
  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = N_APPROACH - 1; i >= 1; i--) begin
      j = (int'(cur_idx) + i) % N_APPROACH;
      if (req[j]) begin
        winner = IDX_W'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Intersection controller: GREEN -> YELLOW -> ALL_RED -> GREEN(next) with min/max green.
// Optional macro TLC_PREEMPT_EN enables emergency-vehicle preemption via preempt/preempt_idx.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int N_APPROACH  = 4,
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 40,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2,
  parameter int TIMER_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  tlc_phase_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(N_APPROACH);

  phase_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [TIMER_W-1:0]   green_cnt, green_cnt_nxt;
  logic [IDX_W-1:0]     cur, cur_nxt;
  logic [IDX_W-1:0]     target, target_nxt;
  logic                 start_q, start_nxt;

  logic [IDX_W-1:0]     rr_winner;
  logic                 rr_valid;
  logic                 leave;
  logic                 preempt_on;
  logic [IDX_W-1:0]     preempt_tgt;

`ifdef TLC_PREEMPT_EN
  assign preempt_on  = bus.preempt;
  assign preempt_tgt = bus.preempt_idx;
`else
  assign preempt_on  = 1'b0;
  assign preempt_tgt = '0;
`endif

  tlc_rr_arbiter #(
    .N_APPROACH (N_APPROACH),
    .IDX_W      (IDX_W)
  ) u_arb (
    .req     (bus.req),
    .cur_idx (cur),
    .winner  (rr_winner),
    .valid   (rr_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PH_ALL_RED;
      timer     <= TIMER_W'(ALLRED_TIME - 1);
      green_cnt <= '0;
      cur       <= '0;
      target    <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      green_cnt <= green_cnt_nxt;
      cur       <= cur_nxt;
      target    <= target_nxt;
      start_q   <= start_nxt;
    end
  end

  // rr_valid doubles as "some other approach is waiting".
  assign leave = (green_cnt >= TIMER_W'(MIN_GREEN)) && rr_valid &&
                 (!bus.req[cur] || (green_cnt >= TIMER_W'(MAX_GREEN)));

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    green_cnt_nxt = green_cnt;
    cur_nxt       = cur;
    target_nxt    = target;
    start_nxt     = 1'b0;

    case (state)
      PH_ALL_RED: begin
        if (timer == '0) begin
          state_nxt     = PH_GREEN;
          cur_nxt       = target;
          green_cnt_nxt = TIMER_W'(1);
          start_nxt     = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      PH_GREEN: begin
        if (leave) begin
          state_nxt  = PH_YELLOW;
          timer_nxt  = TIMER_W'(YELLOW_TIME - 1);
          target_nxt = rr_winner;
        end else if (green_cnt < TIMER_W'(MAX_GREEN)) begin
          green_cnt_nxt = green_cnt + 1'b1;
        end
      end
      PH_YELLOW: begin
        if (timer == '0) begin
          state_nxt = PH_ALL_RED;
          timer_nxt = TIMER_W'(ALLRED_TIME - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = PH_ALL_RED;
        timer_nxt = TIMER_W'(ALLRED_TIME - 1);
      end
    endcase

    // Preemption overrides the normal green rules and retargets the next green.
    if (preempt_on) begin
      target_nxt = preempt_tgt;
      if (state == PH_GREEN) begin
        if (cur != preempt_tgt) begin
          state_nxt = PH_YELLOW;
          timer_nxt = TIMER_W'(YELLOW_TIME - 1);
        end else begin
          state_nxt     = PH_GREEN;
          timer_nxt     = timer;
          green_cnt_nxt = (green_cnt < TIMER_W'(MAX_GREEN)) ? green_cnt + 1'b1 : green_cnt;
        end
      end
    end
  end

  always_comb begin
    logic [2*N_APPROACH-1:0] light_v;
    logic [N_APPROACH-1:0]   grant_v;
    light_v = '0;
    grant_v = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      light_v[2*i +: 2] = LT_RED;
      if (cur == IDX_W'(i)) begin
        if (state == PH_GREEN) begin
          light_v[2*i +: 2] = LT_GREEN;
          grant_v[i]        = 1'b1;
        end else if (state == PH_YELLOW) begin
          light_v[2*i +: 2] = LT_YELLOW;
        end
      end
    end
    bus.light = light_v;
    bus.grant = grant_v;
  end

  assign bus.cur_idx     = cur;
  assign bus.phase_start = start_q;

endmodule
